// File: rtl/alu_sweep_ctrl.sv
// alu_sweep_ctrl: drives one operand pair through ALU opcodes 0..LAST_OP,
// folding each settled result and flag set into a signature and flag counters.
// Ports: clk, rst (async, active-high), start, a_in, b_in -> alu_a, alu_b, alu_op;
//   alu_result, alu_carry/overflow/zero/negative <- ALU;
//   busy, done, sig, zero_cnt, carry_cnt status outputs.
// Optional: define ALU_SWEEP_ABORT_EN to add the abort input and aborted output.
module alu_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int OP_W    = 4,
  parameter int LAST_OP = 12,
  parameter int SETTLE  = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_SWEEP_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_negative,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sig,
  output logic [OP_W:0]    zero_cnt,
  output logic [OP_W:0]    carry_cnt
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int VW = OP_W + 4 + WIDTH;
  localparam logic [OP_W-1:0] LAST   = OP_W'(LAST_OP);
  localparam logic [CW-1:0]   RELOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_DRIVE, S_CAPT, S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OP_W-1:0]  op_q;
  logic             busy_q, done_q;
  logic [15:0]      sig_q, sig_d, v_d;
  logic [OP_W:0]    zc_q, zc_d, cc_q, cc_d;
  logic             abort_w;

`ifdef ALU_SWEEP_ABORT_EN
  logic aborted_q;
  assign abort_w = abort;
  assign aborted = aborted_q;
`else
  assign abort_w = 1'b0;
`endif

  // Capture word is zero-extended to 16 bits before folding.
  always_comb begin
    v_d = '0;
    v_d[VW-1:0] = {op_q, alu_negative, alu_zero,
                   alu_overflow, alu_carry, alu_result};
    sig_d = {sig_q[14:0], 1'b0}
          ^ (sig_q[15] ? 16'h002D : 16'h0000)
          ^ v_d;
    zc_d = zc_q + {{OP_W{1'b0}}, alu_zero};
    cc_d = cc_q + {{OP_W{1'b0}}, alu_carry};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= 16'hFFFF;
      zc_q    <= '0;
      cc_q    <= '0;
`ifdef ALU_SWEEP_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef ALU_SWEEP_ABORT_EN
      aborted_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            op_q    <= '0;
            sig_q   <= 16'hFFFF;
            zc_q    <= '0;
            cc_q    <= '0;
            cnt_q   <= RELOAD;
            busy_q  <= 1'b1;
            state_q <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (abort_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`ifdef ALU_SWEEP_ABORT_EN
            aborted_q <= 1'b1;
`endif
          end else if (cnt_q == '0) begin
            state_q <= S_CAPT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CAPT: begin
          // An abort here wins over the capture: stats keep prior values.
          if (abort_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`ifdef ALU_SWEEP_ABORT_EN
            aborted_q <= 1'b1;
`endif
          end else begin
            sig_q <= sig_d;
            zc_q  <= zc_d;
            cc_q  <= cc_d;
            if (op_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              op_q    <= op_q + 1'b1;
              cnt_q   <= RELOAD;
              state_q <= S_DRIVE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sig       = sig_q;
  assign zero_cnt  = zc_q;
  assign carry_cnt = cc_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// tb_alu_sweep_ctrl: two sweep controllers (default and SETTLE=3/LAST_OP=2)
// with stub ALUs, checked each cycle against a cycle-count reference model.
module tb_alu_sweep_ctrl;

  localparam int S[2] = '{1, 3};
  localparam int L[2] = '{12, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        start[2];
  logic        abort[2];
  logic [3:0]  a_in[2], b_in[2];
  logic [3:0]  alu_a[2], alu_b[2], alu_op[2], alu_res[2];
  logic        fc[2], fo[2], fz[2], fn[2];
  logic        busy[2], done[2];
  logic [15:0] sig[2];
  logic [4:0]  zc[2], cc[2];
  logic        mode[2];
`ifdef ALU_SWEEP_ABORT_EN
  logic        aborted[2];
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stub ALU: result a^b; mode 1 adds zero=1 always, carry=1 on odd opcodes.
  function automatic logic [7:0] stub(input logic m,
                                      input logic [3:0] a, b, op);
    return {1'b0, m, 1'b0, m & op[0], a ^ b};
  endfunction

  assign {fn[0], fz[0], fo[0], fc[0], alu_res[0]} =
    stub(mode[0], alu_a[0], alu_b[0], alu_op[0]);
  assign {fn[1], fz[1], fo[1], fc[1], alu_res[1]} =
    stub(mode[1], alu_a[1], alu_b[1], alu_op[1]);

  alu_sweep_ctrl u0 (
    .clk(clk), .rst(rst),
`ifdef ALU_SWEEP_ABORT_EN
    .abort(abort[0]), .aborted(aborted[0]),
`endif
    .start(start[0]), .a_in(a_in[0]), .b_in(b_in[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
    .alu_result(alu_res[0]), .alu_carry(fc[0]),
    .alu_overflow(fo[0]), .alu_zero(fz[0]), .alu_negative(fn[0]),
    .busy(busy[0]), .done(done[0]), .sig(sig[0]),
    .zero_cnt(zc[0]), .carry_cnt(cc[0])
  );

  alu_sweep_ctrl #(.LAST_OP(2), .SETTLE(3)) u1 (
    .clk(clk), .rst(rst),
`ifdef ALU_SWEEP_ABORT_EN
    .abort(abort[1]), .aborted(aborted[1]),
`endif
    .start(start[1]), .a_in(a_in[1]), .b_in(b_in[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
    .alu_result(alu_res[1]), .alu_carry(fc[1]),
    .alu_overflow(fo[1]), .alu_zero(fz[1]), .alu_negative(fn[1]),
    .busy(busy[1]), .done(done[1]), .sig(sig[1]),
    .zero_cnt(zc[1]), .carry_cnt(cc[1])
  );

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got %0h want %0h", nm, inst, act, exp);
    end
  endtask

  // Reference model: m_n counts cycles since the accepting edge (1-based).
  // Each opcode spans S+1 cycles; its capture is the last of them.
  bit          m_act[2], m_abd[2];
  int          m_n[2], m_zc[2], m_cc[2];
  logic [3:0]  m_a[2], m_b[2], m_op[2];
  logic [15:0] m_sig[2];

  function automatic int tot(input int i);
    return (L[i] + 1) * (S[i] + 1) + 1;
  endfunction

  task automatic fold(input int i, input int op);
    logic [7:0]  f;
    logic [15:0] v;
    f = stub(mode[i], m_a[i], m_b[i], 4'(op));
    v = {4'h0, 4'(op), f};
    m_sig[i] = {m_sig[i][14:0], 1'b0}
             ^ (m_sig[i][15] ? 16'h002D : 16'h0000) ^ v;
    m_zc[i] += int'(f[6]);
    m_cc[i] += int'(f[4]);
  endtask

  task automatic step(input int i);
    m_abd[i] = 1'b0;
    if (!m_act[i]) begin
      if (start[i]) begin
        m_act[i] = 1'b1;
        m_n[i]   = 1;
        m_a[i]   = a_in[i];
        m_b[i]   = b_in[i];
        m_sig[i] = 16'hFFFF;
        m_zc[i]  = 0;
        m_cc[i]  = 0;
      end
    end else if (m_n[i] == tot(i)) begin
      m_act[i] = 1'b0;
    end else if (abort[i]) begin
      m_act[i] = 1'b0;
      m_abd[i] = 1'b1;
    end else begin
      if (m_n[i] % (S[i] + 1) == 0) fold(i, m_n[i] / (S[i] + 1) - 1);
      m_n[i]++;
    end
    if (m_act[i])
      m_op[i] = (m_n[i] < tot(i)) ? 4'((m_n[i] - 1) / (S[i] + 1)) : 4'(L[i]);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_abd[i] = 1'b0; m_n[i] = 0;
        m_a[i] = '0; m_b[i] = '0; m_op[i] = '0;
        m_sig[i] = 16'hFFFF; m_zc[i] = 0; m_cc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) step(i);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, 32'(busy[i]), 32'(m_act[i]));
        chk("done", i, 32'(done[i]), 32'(m_act[i] && m_n[i] == tot(i)));
        chk("alu_a", i, 32'(alu_a[i]), 32'(m_a[i]));
        chk("alu_b", i, 32'(alu_b[i]), 32'(m_b[i]));
        chk("alu_op", i, 32'(alu_op[i]), 32'(m_op[i]));
        chk("sig", i, 32'(sig[i]), 32'(m_sig[i]));
        chk("zero_cnt", i, 32'(zc[i]), m_zc[i]);
        chk("carry_cnt", i, 32'(cc[i]), m_cc[i]);
`ifdef ALU_SWEEP_ABORT_EN
        chk("aborted", i, 32'(aborted[i]), 32'(m_abd[i]));
`endif
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one edge; operands are scrambled right after acceptance.
  task automatic go(input int i, input logic [3:0] a, input logic [3:0] b);
    a_in[i] = a;
    b_in[i] = b;
    start[i] = 1'b1;
    tick(1);
    start[i] = 1'b0;
    a_in[i] = ~a;
    b_in[i] = ~b;
  endtask

  // Observe cycles k0..kmax of a sweep (cycle 1 = first after acceptance).
  task automatic watch(input int i, input int k0, input int kmax,
                       output int bc, output int dc, output int dn,
                       output logic [15:0] s3, output logic [15:0] s5,
                       output logic [4:0] zd, output logic [4:0] cd,
                       output logic [3:0] ad);
    bc = 0; dc = 0; dn = 0; s3 = 'x; s5 = 'x; zd = 'x; cd = 'x; ad = 'x;
    for (int k = k0; k <= kmax; k++) begin
      if (busy[i]) bc++;
      if (done[i]) begin
        dn++; dc = k; zd = zc[i]; cd = cc[i]; ad = alu_a[i];
      end
      if (k == 3) s3 = sig[i];
      if (k == 5) s5 = sig[i];
      tick(1);
    end
  endtask

  int bc, dc, dn;
  logic [15:0] s3, s5;
  logic [4:0] zd, cd;
  logic [3:0] ad;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; mode[i] = 1'b0;
      a_in[i] = '0; b_in[i] = '0;
    end
    tick(2);
    chk("rst_sig", 0, 32'(sig[0]), 32'hFFFF);
    chk("rst_busy", 0, 32'(busy[0]), 0);
    chk("rst_op", 1, 32'(alu_op[1]), 0);
    rst = 1'b0;
    tick(2);

    // Plain sweep, stub result a^b, flags clear.
    go(0, 4'b1010, 4'b0110);
    watch(0, 1, 40, bc, dc, dn, s3, s5, zd, cd, ad);
    chk("t1_busy_cycles", 0, bc, 27);
    chk("t1_done_cycle", 0, dc, 27);
    chk("t1_done_pulses", 0, dn, 1);
    chk("t1_sig_cap0", 0, 32'(s3), 32'hFFDF);
    chk("t1_sig_cap1", 0, 32'(s5), 32'hFE9F);

    // Flag counting.
    mode[0] = 1'b1;
    go(0, 4'h3, 4'h5);
    watch(0, 1, 40, bc, dc, dn, s3, s5, zd, cd, ad);
    chk("t2_done_cycle", 0, dc, 27);
    chk("t2_zero_cnt", 0, 32'(zd), 13);
    chk("t2_carry_cnt", 0, 32'(cd), 6);
    mode[0] = 1'b0;

    // SETTLE=3, LAST_OP=2; operands change during the sweep.
    go(1, 4'h9, 4'h2);
    a_in[1] = 4'hF;
    watch(1, 1, 20, bc, dc, dn, s3, s5, zd, cd, ad);
    chk("t3_done_cycle", 1, dc, 13);
    chk("t3_busy_cycles", 1, bc, 13);
    chk("t3_alu_a", 1, 32'(ad), 32'h9);

    // Second start in cycle 10 is ignored.
    go(0, 4'b1010, 4'b0110);
    tick(9);
    start[0] = 1'b1;
    a_in[0] = 4'h1;
    tick(1);
    start[0] = 1'b0;
    watch(0, 11, 40, bc, dc, dn, s3, s5, zd, cd, ad);
    chk("t4_done_cycle", 0, dc, 27);
    chk("t4_done_pulses", 0, dn, 1);
    chk("t4_alu_a", 0, 32'(ad), 32'hA);

    // Asynchronous reset in cycle 8.
    mode[0] = 1'b1;
    go(0, 4'h7, 4'h1);
    tick(7);
    #3 rst = 1'b1;
    #1;
    chk("t5_busy", 0, 32'(busy[0]), 0);
    chk("t5_sig", 0, 32'(sig[0]), 32'hFFFF);
    chk("t5_op", 0, 32'(alu_op[0]), 0);
    chk("t5_alu_a", 0, 32'(alu_a[0]), 0);
    chk("t5_zero_cnt", 0, 32'(zc[0]), 0);
    #2 rst = 1'b0;
    tick(1);
    watch(0, 1, 30, bc, dc, dn, s3, s5, zd, cd, ad);
    chk("t5_no_done", 0, dn, 0);
    go(0, 4'h7, 4'h1);
    watch(0, 1, 40, bc, dc, dn, s3, s5, zd, cd, ad);
    chk("t5_fresh_done", 0, dc, 27);
    chk("t5_fresh_zero", 0, 32'(zd), 13);

`ifdef ALU_SWEEP_ABORT_EN
    // Abort in cycle 5 after two captures (mode 1 flags).
    go(0, 4'b1010, 4'b0110);
    tick(4);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    chk("t6_aborted", 0, 32'(aborted[0]), 1);
    chk("t6_busy", 0, 32'(busy[0]), 0);
    chk("t6_sig", 0, 32'(sig[0]), 32'hFE4F);
    chk("t6_zero_cnt", 0, 32'(zc[0]), 2);
    chk("t6_carry_cnt", 0, 32'(cc[0]), 1);
    watch(0, 1, 30, bc, dc, dn, s3, s5, zd, cd, ad);
    chk("t6_no_done", 0, dn, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
